// File: rtl/ebi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ebi_pkg                                                       |
// | Brief    : Shared region decode and control-register constants.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package ebi_pkg;

    typedef enum logic [1:0] {
        REGION_VRAM = 2'b00,
        REGION_OAM  = 2'b01,
        REGION_PAL  = 2'b10,
        REGION_CTRL = 2'b11
    } region_t;

    localparam int REGION_MSB = 15;
    localparam int REGION_LSB = 14;

    localparam logic [1:0] CTRL_OFS     = 2'd0;
    localparam logic [1:0] SCROLL_X_OFS = 2'd1;
    localparam logic [1:0] SCROLL_Y_OFS = 2'd2;

    localparam int CTRL_OVF_CLR_BIT = 15;
    localparam int CTRL_DISP_EN_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sync_fifo                                                     |
// | Brief    : Single-clock FIFO with occupancy count, show-ahead read.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int                c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full    = (r_count == c_DEPTH);
    assign empty   = (r_count == '0);
    assign level   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ebi_write_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ebi_write_dispatcher                                          |
// | Brief    : Buffers EBI writes, routes them to VRAM/OAM/palette ports or   |
// |            the local display control registers.                          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ebi_write_dispatcher
    import ebi_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             address_in,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          data_ready,
    output logic [ADDR_W-3:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data,
    output logic                          vram_we,
    output logic                          oam_we,
    output logic                          pal_we,
    input  logic                          mem_ready,
    output logic                          display_enable,
    output logic [DATA_W-1:0]             scroll_x,
    output logic [DATA_W-1:0]             scroll_y,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int        c_FIFO_W = ADDR_W + DATA_W;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_FIFO_W-1:0] w_head;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;
    region_t             w_head_region;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_drop;
    region_t             r_region;
    logic [ADDR_W-3:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_data;
    logic                r_display_enable;
    logic [DATA_W-1:0]   r_scroll_x;
    logic [DATA_W-1:0]   r_scroll_y;
    logic                r_overflow;

    sync_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (data_ready),
        .wr_data ({address_in, data_in}),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    assign w_head_addr   = w_head[c_FIFO_W-1:DATA_W];
    assign w_head_data   = w_head[DATA_W-1:0];
    assign w_head_region = region_t'(w_head_addr[REGION_MSB:REGION_LSB]);
    assign w_pop         = (r_state == S_IDLE) && !w_empty;
    assign w_drop        = data_ready && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && (w_head_region != REGION_CTRL)) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Only memory-region pops load the issue registers, keeping them stable in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_region   <= REGION_VRAM;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else if (w_pop && (w_head_region != REGION_CTRL)) begin
            r_region   <= w_head_region;
            r_mem_addr <= w_head_addr[ADDR_W-3:0];
            r_mem_data <= w_head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_display_enable <= 1'b0;
            r_scroll_x       <= '0;
            r_scroll_y       <= '0;
            r_overflow       <= 1'b0;
        end else begin
            if (w_pop && (w_head_region == REGION_CTRL)) begin
                case (w_head_addr[1:0])
                    CTRL_OFS: begin
                        r_display_enable <= w_head_data[CTRL_DISP_EN_BIT];
                        if (w_head_data[CTRL_OVF_CLR_BIT]) begin
                            r_overflow <= 1'b0;
                        end
                    end
                    SCROLL_X_OFS: r_scroll_x <= w_head_data;
                    SCROLL_Y_OFS: r_scroll_y <= w_head_data;
                    default: ;
                endcase
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign vram_we        = (r_state == S_ISSUE) && (r_region == REGION_VRAM);
    assign oam_we         = (r_state == S_ISSUE) && (r_region == REGION_OAM);
    assign pal_we         = (r_state == S_ISSUE) && (r_region == REGION_PAL);
    assign mem_addr       = r_mem_addr;
    assign mem_data       = r_mem_data;
    assign display_enable = r_display_enable;
    assign scroll_x       = r_scroll_x;
    assign scroll_y       = r_scroll_y;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ebi_write_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ebi_write_dispatcher                                       |
// | Brief    : Directed self-checking bench for ebi_write_dispatcher.         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ebi_write_dispatcher;

    logic        clk;
    logic        reset;
    logic [15:0] address_in;
    logic [15:0] data_in;
    logic        data_ready;
    logic [13:0] mem_addr;
    logic [15:0] mem_data;
    logic        vram_we;
    logic        oam_we;
    logic        pal_we;
    logic        mem_ready;
    logic        display_enable;
    logic [15:0] scroll_x;
    logic [15:0] scroll_y;
    logic        overflow;
    logic [3:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;
    int we_cycles = 0;
    int onehot_err = 0;
    int base_we;
    logic [1:0]  log_kind [$];
    logic [13:0] log_addr [$];
    logic [15:0] log_data [$];

    ebi_write_dispatcher #(
        .FIFO_DEPTH (8),
        .ADDR_W     (16),
        .DATA_W     (16)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .address_in     (address_in),
        .data_in        (data_in),
        .data_ready     (data_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .vram_we        (vram_we),
        .oam_we         (oam_we),
        .pal_we         (pal_we),
        .mem_ready      (mem_ready),
        .display_enable (display_enable),
        .scroll_x       (scroll_x),
        .scroll_y       (scroll_y),
        .overflow       (overflow),
        .fifo_level     (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: logs every accepted write and flags multi-hot strobes.
    always @(posedge clk) begin
        if (!reset) begin
            if ($countones({vram_we, oam_we, pal_we}) > 1) onehot_err++;
            if (vram_we || oam_we || pal_we) we_cycles++;
            if ((vram_we || oam_we || pal_we) && mem_ready) begin
                log_kind.push_back(vram_we ? 2'd0 : (oam_we ? 2'd1 : 2'd2));
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_data);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        address_in = a;
        data_in    = d;
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
    endtask

    task automatic clear_log();
        log_kind.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic wait_log(input int n);
        for (int c = 0; c < 80 && log_data.size() < n; c++) step();
        repeat (4) step();
        check("log_count", log_data.size(), n);
    endtask

    initial begin
        reset      = 1'b1;
        address_in = '0;
        data_in    = '0;
        data_ready = 1'b0;
        mem_ready  = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_we", {vram_we, oam_we, pal_we}, 3'b000);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_disp", display_enable, 0);
        check("rst_sx", scroll_x, 0);
        check("rst_sy", scroll_y, 0);
        reset = 1'b0;
        step();

        // 1: VRAM write, single-cycle strobe at N+2
        push(16'h0005, 16'h0032);
        check("t1_n1_we", vram_we, 0);
        step();
        check("t1_vram_we", vram_we, 1);
        check("t1_addr", mem_addr, 14'h0005);
        check("t1_data", mem_data, 16'h0032);
        step();
        check("t1_we_drop", vram_we, 0);

        // 2: OAM write stalled 5 cycles
        mem_ready = 1'b0;
        push(16'h4010, 16'hBEEF);
        step();
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i == 5);
            check("t2_oam_we", oam_we, 1);
            check("t2_addr", mem_addr, 14'h0010);
            check("t2_data", mem_data, 16'hBEEF);
            step();
        end
        check("t2_oam_done", oam_we, 0);
        mem_ready = 1'b1;

        // 3: control writes never strobe memory
        base_we = we_cycles;
        push(16'hC001, 16'h0123);
        push(16'hC000, 16'h0001);
        step();
        step();
        check("t3_scroll_x", scroll_x, 16'h0123);
        check("t3_disp", display_enable, 1);
        check("t3_no_we", we_cycles, base_we);

        // 4: blocker in ISSUE, 9 pushes -> 8 buffered, 9th dropped
        clear_log();
        mem_ready = 1'b0;
        push(16'h0100, 16'h0000);
        for (int i = 1; i <= 9; i++) push(16'h0100 + 16'(i), 16'(i));
        check("t4_level", fifo_level, 8);
        check("t4_ovf", overflow, 1);
        mem_ready = 1'b1;
        wait_log(9);
        for (int i = 0; i < 9 && i < log_data.size(); i++) begin
            check("t4_order_data", log_data[i], i);
            check("t4_order_addr", log_addr[i], 14'h0100 + 14'(i));
        end

        // 5: clear overflow, fill, coincident push+pop, then a real drop
        push(16'hC000, 16'h8001);
        step();
        check("t5_ovf_clr0", overflow, 0);
        check("t5_disp_kept", display_enable, 1);
        clear_log();
        mem_ready = 1'b0;
        push(16'h0200, 16'h0000);
        for (int i = 1; i <= 8; i++) push(16'h0200 + 16'(i), 16'(i));
        check("t5_full", fifo_level, 8);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        push(16'h02CC, 16'h00CC);
        check("t5_level_same", fifo_level, 8);
        check("t5_ovf_stays", overflow, 0);
        check("t5_next_issue", vram_we, 1);
        push(16'h02DD, 16'h00DD);
        check("t5_drop_ovf", overflow, 1);
        mem_ready = 1'b1;
        wait_log(10);
        if (log_data.size() == 10) check("t5_last", log_data[9], 16'h00CC);
        push(16'hC000, 16'h8000);
        step();
        check("t5_ovf_clr", overflow, 0);
        check("t5_disp_off", display_enable, 0);

        // 6: reset during a palette ISSUE
        push(16'hC001, 16'h00AA);
        push(16'hC002, 16'h00BB);
        push(16'hC000, 16'h0001);
        mem_ready = 1'b0;
        push(16'h8003, 16'h001F);
        push(16'h0007, 16'h0007);
        check("t6_pal_we", pal_we, 1);
        check("t6_addr", mem_addr, 14'h0003);
        check("t6_sy_set", scroll_y, 16'h00BB);
        reset = 1'b1;
        step();
        check("t6_pal_off", pal_we, 0);
        check("t6_level", fifo_level, 0);
        check("t6_ovf", overflow, 0);
        check("t6_sx", scroll_x, 0);
        check("t6_sy", scroll_y, 0);
        check("t6_disp", display_enable, 0);
        reset = 1'b0;
        mem_ready = 1'b1;
        base_we = we_cycles;
        repeat (4) step();
        check("t6_discarded", we_cycles, base_we);

        check("onehot", onehot_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
